axi_aw_arbiter_xbar: RTL and testbench
======================================

Name: axi_aw_arbiter_xbar

Overview:
- Parametrised N-master to (S+1)-slave AXI write-address (AW) router. Slaves are S mapped slaves plus one default slave.
- Round-robin arbitration between masters. AW payload is registered and forwarded to the slave selected by address decode.
- Grant is held until the routed write response (B) completes. The AXI bridge therefore carries exactly one write transaction at a time.
- Exports a routing tag so the W and B channel muxes can follow the granted master/slave pair.

Parameters:
- NUM_M, 2, number of masters (1..8)
- NUM_S, 5, number of mapped slaves; default slave index = NUM_S
- ID_W, 4, master-side AWID width
- IDS_W, ID_W+4, slave-side ID width: {4-bit master index, AWID}
- ADDR_W, 32, address width
- LEN_W, 4, AWLEN width
- SIZE_W, 3, AWSIZE width
- TIMEOUT_CYC, 1024, watchdog limit (optional feature only)

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- AWID_M  in  NUM_M*ID_W  per-master AWID, packed, master 0 in the LSBs
- AWADDR_M  in  NUM_M*ADDR_W  per-master AWADDR
- AWLEN_M  in  NUM_M*LEN_W  per-master AWLEN
- AWSIZE_M  in  NUM_M*SIZE_W  per-master AWSIZE
- AWBURST_M  in  NUM_M*2  per-master AWBURST
- AWVALID_M  in  NUM_M  per-master AWVALID
- AWREADY_M  out  NUM_M  per-master AWREADY
- AWID_S  out  IDS_W  registered ID, broadcast to all slaves
- AWADDR_S  out  ADDR_W  registered address, broadcast
- AWLEN_S  out  LEN_W  registered length, broadcast
- AWSIZE_S  out  SIZE_W  registered size, broadcast
- AWBURST_S  out  2  registered burst, broadcast
- AWVALID_S  out  NUM_S+1  one-hot valid; bit NUM_S is the default slave
- AWREADY_S  in  NUM_S+1  per-slave ready
- BDONE_S  in  NUM_S+1  one-cycle pulse when the B handshake of that slave completes
- route_vld  out  1  high from slave AW handshake until B completes
- route_m  out  3  granted master index
- route_s  out  3  selected slave index
- aw_fire  out  1  one-cycle pulse on slave AW handshake

Behaviour:
- Reset (ARESET=1, asynchronous):
  - state=IDLE, RR pointer=0
  - all AWVALID_S=0, AWREADY_M=0, route_vld=0, aw_fire=0
  - payload registers=0, route_m=0, route_s=0
- Reset asserted mid-transaction abandons the transaction; no completion is signalled.
- FSM states: IDLE, SEND, WAIT_B.
- IDLE:
  - If any AWVALID_M is set, the round-robin winner is the first requester at or after the RR pointer.
  - AWREADY_M[winner]=1 combinationally in that cycle; all other AWREADY_M=0.
  - Payload, ID prefix and decoded slave are captured on the clock edge; next state SEND.
- Decode:
  - Slave i is selected when BASE[i] <= addr < LIMIT[i]. The lowest matching index wins.
  - No match selects the default slave (index NUM_S).
- SEND:
  - AWVALID_S[route_s]=1; all AWREADY_M=0.
  - On AWREADY_S[route_s]: aw_fire=1 for one cycle, next state WAIT_B, route_vld=1.
  - AWREADY_S bits of non-selected slaves are ignored.
- WAIT_B:
  - On BDONE_S[route_s]: route_vld=0, RR pointer=winner+1 mod NUM_M, next state IDLE. A new grant is possible in the following cycle.
- Latency: master handshake in cycle N puts AWVALID_S high in cycle N+1. Minimum turnaround per transaction is 3 cycles plus slave/B wait.
- Simultaneous requests: only the winner is acknowledged. Losers keep AWVALID and are served in later rounds; no starvation (max wait NUM_M-1 transactions).
- BDONE_S pulses in IDLE/SEND, or for a non-selected slave, are ignored.
- route_m and route_s stay stable from IDLE capture until the return to IDLE.

Optional Feature:
- Macro: AXI_AW_WATCHDOG_EN
- Defined:
  - A counter runs in SEND and WAIT_B and clears on state change.
  - On reaching TIMEOUT_CYC: the FSM forces IDLE, drops AWVALID_S and route_vld, pulses an extra output timeout_err for 1 cycle, and advances the RR pointer.
- Undefined: no counter and no timeout_err port; the FSM waits indefinitely.

Decomposition:
- Package axi_xbar_pkg holds:
  - state enum aw_state_e
  - address map constant arrays S_BASE/S_LIMIT, defaults:
    - S0 0x0001_0000–0x0002_0000
    - S1 0x0002_0000–0x0003_0000
    - S2 0x1000_0000–0x1000_0400
    - S3 0x1001_0000–0x1001_0400
    - S4 0x2000_0000–0x2020_0000
  - DEFAULT_SLV index constant
- One sub-module: rr_arbiter (request vector, pointer in; one-hot grant and index out; purely combinational). It is reusable for the AR channel.

Test Plan:
- Single write, M0 addr 0x0002_0010, AWID 3 -> AWREADY_M[0] in cycle N; AWVALID_S[1] in N+1 with AWID_S=0x03. AWREADY_S[1] at N+3 gives aw_fire at N+3 and route_s=1. BDONE_S[1] returns to IDLE.
- Unmapped addr 0x3000_0000 from M1 -> AWVALID_S[5] (default slave) with AWID_S={4'd1, id}.
- M0 and M1 request continuously -> grants alternate M0, M1, M0, M1 across 4 transactions; each master sees AWREADY_M exactly once per grant.
- A second request during WAIT_B -> AWREADY_M stays 0 until the cycle after BDONE_S. A spurious BDONE_S[2] while route_s=1 is ignored.
- ARESET pulsed asynchronously during SEND -> AWVALID_S=0 immediately. After release, the next request goes to M0 first with the pointer reset.
- With AXI_AW_WATCHDOG_EN and TIMEOUT_CYC=16, slave never ready -> timeout_err at cycle 16 after SEND entry; FSM in IDLE; next request granted.

Source files
------------

// File: rtl/axi_xbar_pkg.sv
// Shared types and the address map for the AXI crossbar channel routers.
// The address decode helper is reused by the AW and AR routers.
package axi_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2
  } aw_state_e;

  localparam int MAP_N       = 5;
  localparam int DEFAULT_SLV = MAP_N;

  // Half-open windows: BASE <= addr < LIMIT
  localparam logic [31:0] S_BASE [MAP_N] = '{
    32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h1001_0000, 32'h2000_0000
  };
  localparam logic [31:0] S_LIMIT [MAP_N] = '{
    32'h0002_0000, 32'h0003_0000, 32'h1000_0400, 32'h1001_0400, 32'h2020_0000
  };

  // Lowest matching window wins; no match maps to index num_s (default slave).
  function automatic logic [2:0] addr_decode(input logic [31:0] addr, input int num_s);
    logic [2:0] sel;
    sel = 3'(num_s);
    for (int i = MAP_N - 1; i >= 0; i--) begin
      if (i < num_s && addr >= S_BASE[i] && addr < S_LIMIT[i]) begin
        sel = 3'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/axi_aw_arbiter_xbar_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr.
// Zero latency; no flow control of its own, the caller decides when a grant is taken.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  // First pass covers [ptr, N-1], second pass wraps around to [0, ptr-1].
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_aw_arbiter_xbar.sv
// N-master to (S+1)-slave AW router; grant held until routed B completes. AWVALID_S one cycle after master handshake.
// One transaction in flight; masters see AWREADY only in IDLE. AXI_AW_WATCHDOG_EN adds a timeout and timeout_err.
module axi_aw_arbiter_xbar
  import axi_xbar_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int NUM_S       = 5,
  parameter int ID_W        = 4,
  parameter int IDS_W       = ID_W + 4,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 4,
  parameter int SIZE_W      = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [NUM_M*ID_W-1:0]    AWID_M,
  input  logic [NUM_M*ADDR_W-1:0]  AWADDR_M,
  input  logic [NUM_M*LEN_W-1:0]   AWLEN_M,
  input  logic [NUM_M*SIZE_W-1:0]  AWSIZE_M,
  input  logic [NUM_M*2-1:0]       AWBURST_M,
  input  logic [NUM_M-1:0]         AWVALID_M,
  output logic [NUM_M-1:0]         AWREADY_M,
  output logic [IDS_W-1:0]         AWID_S,
  output logic [ADDR_W-1:0]        AWADDR_S,
  output logic [LEN_W-1:0]         AWLEN_S,
  output logic [SIZE_W-1:0]        AWSIZE_S,
  output logic [1:0]               AWBURST_S,
  output logic [NUM_S:0]           AWVALID_S,
  input  logic [NUM_S:0]           AWREADY_S,
  input  logic [NUM_S:0]           BDONE_S,
  output logic                     route_vld,
  output logic [2:0]               route_m,
  output logic [2:0]               route_s,
  output logic                     aw_fire
`ifdef AXI_AW_WATCHDOG_EN
  ,
  output logic                     timeout_err
`endif
);

  aw_state_e         state, state_nxt;
  logic [2:0]        rr_ptr;
  logic [2:0]        gnt_idx;
  logic [NUM_M-1:0]  gnt;
  logic              any_req, take, adv_ptr;
  logic [NUM_S:0]    slv_oh;
  logic              sel_rdy, sel_bdone, wd_hit;

  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] win_addr;
  logic [LEN_W-1:0]  win_len;
  logic [SIZE_W-1:0] win_size;
  logic [1:0]        win_burst;
  logic [2:0]        win_slv;

  assign any_req = |AWVALID_M;

  rr_arbiter #(.N(NUM_M), .IDX_W(3)) u_rr (
    .req     (AWVALID_M),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    win_id    = '0;
    win_addr  = '0;
    win_len   = '0;
    win_size  = '0;
    win_burst = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt[i]) begin
        win_id    = AWID_M[i*ID_W +: ID_W];
        win_addr  = AWADDR_M[i*ADDR_W +: ADDR_W];
        win_len   = AWLEN_M[i*LEN_W +: LEN_W];
        win_size  = AWSIZE_M[i*SIZE_W +: SIZE_W];
        win_burst = AWBURST_M[i*2 +: 2];
      end
    end
    win_slv = addr_decode(32'(win_addr), NUM_S);
  end

  // Only the routed slave's ready/done count; the rest are ignored.
  always_comb begin
    slv_oh = '0;
    for (int i = 0; i <= NUM_S; i++) begin
      slv_oh[i] = (route_s == 3'(i));
    end
  end

  assign sel_rdy   = |(AWREADY_S & slv_oh);
  assign sel_bdone = |(BDONE_S & slv_oh);

`ifdef AXI_AW_WATCHDOG_EN
  logic [31:0] wd_cnt;
  assign wd_hit = (state != IDLE) && (wd_cnt == 32'(TIMEOUT_CYC - 1));
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    AWREADY_M = '0;
    AWVALID_S = '0;
    aw_fire   = 1'b0;
    route_vld = 1'b0;
    adv_ptr   = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !ARESET) begin
          AWREADY_M = gnt;
          take      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        AWVALID_S = slv_oh;
        if (sel_rdy) begin
          aw_fire   = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        route_vld = 1'b1;
        if (sel_bdone) begin
          adv_ptr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wd_hit) begin
      AWVALID_S = '0;
      aw_fire   = 1'b0;
      route_vld = 1'b0;
      adv_ptr   = 1'b1;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      AWID_S    <= '0;
      AWADDR_S  <= '0;
      AWLEN_S   <= '0;
      AWSIZE_S  <= '0;
      AWBURST_S <= '0;
      route_m   <= '0;
      route_s   <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        AWID_S    <= {4'(gnt_idx), win_id};
        AWADDR_S  <= win_addr;
        AWLEN_S   <= win_len;
        AWSIZE_S  <= win_size;
        AWBURST_S <= win_burst;
        route_m   <= gnt_idx;
        route_s   <= win_slv;
      end
      if (adv_ptr) begin
        rr_ptr <= (route_m >= 3'(NUM_M - 1)) ? 3'd0 : route_m + 3'd1;
      end
    end
  end

`ifdef AXI_AW_WATCHDOG_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_hit;
      if (state_nxt != state) begin
        wd_cnt <= '0;
      end else if (state != IDLE) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_aw_arbiter_xbar.sv
// Bench for axi_aw_arbiter_xbar: scoreboard of expected slave-side AW beats plus cycle-exact handshake checks.
module tb_axi_aw_arbiter_xbar;

  localparam int NUM_M = 2, NUM_S = 5, ID_W = 4, IDS_W = 8, ADDR_W = 32, LEN_W = 4, SIZE_W = 3;

  logic                    ACLK = 1'b0;
  logic                    ARESET;
  logic [NUM_M*ID_W-1:0]   AWID_M;
  logic [NUM_M*ADDR_W-1:0] AWADDR_M;
  logic [NUM_M*LEN_W-1:0]  AWLEN_M;
  logic [NUM_M*SIZE_W-1:0] AWSIZE_M;
  logic [NUM_M*2-1:0]      AWBURST_M;
  logic [NUM_M-1:0]        AWVALID_M, AWREADY_M;
  logic [IDS_W-1:0]        AWID_S;
  logic [ADDR_W-1:0]       AWADDR_S;
  logic [LEN_W-1:0]        AWLEN_S;
  logic [SIZE_W-1:0]       AWSIZE_S;
  logic [1:0]              AWBURST_S;
  logic [NUM_S:0]          AWVALID_S, AWREADY_S, BDONE_S;
  logic                    route_vld, aw_fire;
  logic [2:0]              route_m, route_s;
`ifdef AXI_AW_WATCHDOG_EN
  logic                    timeout_err;
`endif

  logic [NUM_S:0] man_rdy, man_bdone, auto_bdone;
  logic           auto_en;
  assign AWREADY_S = man_rdy | {(NUM_S+1){auto_en}};
  assign BDONE_S   = man_bdone | auto_bdone;

  axi_aw_arbiter_xbar dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S), .BDONE_S(BDONE_S),
    .route_vld(route_vld), .route_m(route_m), .route_s(route_s), .aw_fire(aw_fire)
`ifdef AXI_AW_WATCHDOG_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [NUM_S:0]    vs;
    logic [IDS_W-1:0]  id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [1:0]        burst;
    int                slv;
    int                m;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   rdy_cnt[NUM_M];
  int   total = 0, bad = 0;
  int   fire_cnt = 0;
  int   b_cnt = 0, b_slv = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_dec(input logic [31:0] a);
    if (a >= 32'h0001_0000 && a < 32'h0002_0000) return 0;
    if (a >= 32'h0002_0000 && a < 32'h0003_0000) return 1;
    if (a >= 32'h1000_0000 && a < 32'h1000_0400) return 2;
    if (a >= 32'h1001_0000 && a < 32'h1001_0400) return 3;
    if (a >= 32'h2000_0000 && a < 32'h2020_0000) return 4;
    return 5;
  endfunction

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [3:0] id,
                       input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    AWID_M[m*ID_W +: ID_W]       = id;
    AWADDR_M[m*ADDR_W +: ADDR_W] = a;
    AWLEN_M[m*LEN_W +: LEN_W]    = len;
    AWSIZE_M[m*SIZE_W +: SIZE_W] = size;
    AWBURST_M[m*2 +: 2]          = burst;
  endtask

  task automatic push_exp(input int m, input logic [31:0] a, input logic [3:0] id,
                          input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
    exp_t e;
    e.slv       = ref_dec(a);
    e.m         = m;
    e.vs        = '0;
    e.vs[e.slv] = 1'b1;
    e.id        = {4'(m), id};
    e.addr      = a;
    e.len       = len;
    e.size      = size;
    e.burst     = burst;
    sb.push_back(e);
  endtask

  // Waits for the in-flight transaction to drain back to an idle bridge.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (n < 60 && !(sb.size() == 0 && !aw_fire && !route_vld &&
                           AWVALID_S == '0 && b_cnt == 0 && auto_bdone == '0));
    if (n >= 60) chk({tag, "_drain_timeout"}, 64'(n), 64'(0));
  endtask

  task automatic run_one(input int m, input logic [31:0] a, input logic [3:0] id, input string tag);
    int n;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    len   = id ^ 4'hA;
    size  = 3'(m + 1);
    burst = id[1:0];
    cyc();
    set_m(m, a, id, len, size, burst);
    AWVALID_M[m] = 1'b1;
    push_exp(m, a, id, len, size, burst);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (n < 30 && !AWREADY_M[m]);
    if (n >= 30) chk({tag, "_grant_timeout"}, 64'(n), 64'(0));
    cyc();
    AWVALID_M[m] = 1'b0;
    wait_done(tag);
  endtask

  // Slave-side monitor: pops the scoreboard on each AW handshake and answers with B when in auto mode.
  initial begin
    exp_t e;
    auto_bdone = '0;
    forever begin
      @(negedge ACLK);
      auto_bdone = '0;
      if (ARESET) begin
        b_cnt = 0;
      end else begin
        if (b_cnt == 1) begin
          auto_bdone[b_slv] = 1'b1;
          b_cnt = 0;
        end
        chk("rdy_onehot", 64'($countones(AWREADY_M) <= 1), 64'(1));
        for (int i = 0; i < NUM_M; i++) begin
          if (AWREADY_M[i]) begin
            rdy_cnt[i]++;
            if (AWVALID_M[i]) gnt_log.push_back(i);
          end
        end
        if (aw_fire) begin
          fire_cnt++;
          if (sb.size() == 0) begin
            chk("sb_underflow", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("aws_vld", 64'(AWVALID_S), 64'(e.vs));
            chk("aws_id", 64'(AWID_S), 64'(e.id));
            chk("aws_addr", 64'(AWADDR_S), 64'(e.addr));
            chk("aws_len", 64'(AWLEN_S), 64'(e.len));
            chk("aws_size", 64'(AWSIZE_S), 64'(e.size));
            chk("aws_burst", 64'(AWBURST_S), 64'(e.burst));
            chk("route_s", 64'(route_s), 64'(e.slv));
            chk("route_m", 64'(route_m), 64'(e.m));
            if (auto_en) begin
              b_slv = e.slv;
              b_cnt = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n0, r0, r1, n;
    ARESET = 1'b1;
    AWID_M = '0; AWADDR_M = '0; AWLEN_M = '0; AWSIZE_M = '0; AWBURST_M = '0;
    AWVALID_M = 2'b11;
    man_rdy = '0; man_bdone = '0; auto_en = 1'b0;
    #12;
    chk("rst_awready_m", 64'(AWREADY_M), 64'(0));
    chk("rst_awvalid_s", 64'(AWVALID_S), 64'(0));
    chk("rst_route_vld", 64'(route_vld), 64'(0));
    chk("rst_aw_fire", 64'(aw_fire), 64'(0));
    chk("rst_route", 64'({route_m, route_s}), 64'(0));
    chk("rst_payload", 64'({AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S}), 64'(0));
    AWVALID_M = '0;
    cyc();
    ARESET = 1'b0;

    // Single write, manual slave, cycle-exact.
    cyc();
    set_m(0, 32'h0002_0010, 4'd3, 4'd2, 3'd2, 2'd1);
    AWVALID_M = 2'b01;
    push_exp(0, 32'h0002_0010, 4'd3, 4'd2, 3'd2, 2'd1);
    @(negedge ACLK);
    chk("t1_awready_n", 64'(AWREADY_M), 64'(2'b01));
    chk("t1_awvalid_s_n", 64'(AWVALID_S), 64'(0));
    cyc();
    AWVALID_M = '0;
    @(negedge ACLK);
    chk("t1_awvalid_s_n1", 64'(AWVALID_S), 64'(6'b000010));
    chk("t1_awid_s", 64'(AWID_S), 64'(8'h03));
    chk("t1_awready_send", 64'(AWREADY_M), 64'(0));
    cyc();
    man_rdy = 6'b000100;
    @(negedge ACLK);
    chk("t1_other_rdy_ignored", 64'(aw_fire), 64'(0));
    chk("t1_hold_n2", 64'(AWVALID_S), 64'(6'b000010));
    cyc();
    man_rdy = 6'b000010;
    @(negedge ACLK);
    chk("t1_fire_n3", 64'(aw_fire), 64'(1));
    chk("t1_route_s", 64'(route_s), 64'(1));
    cyc();
    man_rdy = '0;
    @(negedge ACLK);
    chk("t1_route_vld", 64'(route_vld), 64'(1));
    chk("t1_vlds_off", 64'(AWVALID_S), 64'(0));
    cyc();
    man_bdone = 6'b000010;
    @(negedge ACLK);
    chk("t1_vld_at_b", 64'(route_vld), 64'(1));
    cyc();
    man_bdone = '0;
    @(negedge ACLK);
    chk("t1_idle", 64'(route_vld), 64'(0));

    // Address map edges (auto slave).
    auto_en = 1'b1;
    run_one(0, 32'h0000_FFFF, 4'd1, "dec_below_s0");
    run_one(0, 32'h0002_0000, 4'd2, "dec_s1_base");
    run_one(0, 32'h1000_03FC, 4'd4, "dec_s2_top");
    run_one(0, 32'h1000_0400, 4'd5, "dec_s2_limit");
    run_one(0, 32'h1001_0000, 4'd6, "dec_s3_base");
    run_one(0, 32'h201F_FFFF, 4'd7, "dec_s4_top");
    // Unmapped address from M1 goes to the default slave.
    run_one(1, 32'h3000_0000, 4'd5, "t2_default");

    // Continuous requests from both masters alternate.
    cyc();
    set_m(0, 32'h1000_0000, 4'd1, 4'd0, 3'd2, 2'd1);
    set_m(1, 32'h2000_0100, 4'd2, 4'd3, 3'd1, 2'd2);
    push_exp(0, 32'h1000_0000, 4'd1, 4'd0, 3'd2, 2'd1);
    push_exp(1, 32'h2000_0100, 4'd2, 4'd3, 3'd1, 2'd2);
    push_exp(0, 32'h1000_0000, 4'd1, 4'd0, 3'd2, 2'd1);
    push_exp(1, 32'h2000_0100, 4'd2, 4'd3, 3'd1, 2'd2);
    n0 = gnt_log.size();
    r0 = rdy_cnt[0];
    r1 = rdy_cnt[1];
    AWVALID_M = 2'b11;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (n < 100 && gnt_log.size() < n0 + 4);
    cyc();
    AWVALID_M = '0;
    wait_done("t3");
    chk("t3_grant_cnt", 64'(gnt_log.size() - n0), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (gnt_log.size() > n0 + k) chk($sformatf("t3_order%0d", k), 64'(gnt_log[n0 + k]), 64'(k % 2));
    end
    chk("t3_rdy_m0", 64'(rdy_cnt[0] - r0), 64'(2));
    chk("t3_rdy_m1", 64'(rdy_cnt[1] - r1), 64'(2));

    // Request during WAIT_B, spurious B from a non-routed slave.
    auto_en = 1'b0;
    cyc();
    set_m(0, 32'h0002_0100, 4'd6, 4'd1, 3'd3, 2'd1);
    AWVALID_M = 2'b01;
    push_exp(0, 32'h0002_0100, 4'd6, 4'd1, 3'd3, 2'd1);
    @(negedge ACLK);
    chk("t4_gnt_m0", 64'(AWREADY_M), 64'(2'b01));
    cyc();
    AWVALID_M = '0;
    man_rdy = 6'b000010;
    @(negedge ACLK);
    chk("t4_fire", 64'(aw_fire), 64'(1));
    cyc();
    man_rdy = '0;
    set_m(1, 32'h1000_0010, 4'd7, 4'd2, 3'd1, 2'd0);
    AWVALID_M = 2'b10;
    push_exp(1, 32'h1000_0010, 4'd7, 4'd2, 3'd1, 2'd0);
    @(negedge ACLK);
    chk("t4_waitb_rdy", 64'(AWREADY_M), 64'(0));
    cyc();
    man_bdone = 6'b000100;
    @(negedge ACLK);
    chk("t4_spur_rdy", 64'(AWREADY_M), 64'(0));
    cyc();
    man_bdone = '0;
    @(negedge ACLK);
    chk("t4_spur_vld", 64'(route_vld), 64'(1));
    chk("t4_spur_rdy2", 64'(AWREADY_M), 64'(0));
    cyc();
    man_bdone = 6'b000010;
    @(negedge ACLK);
    chk("t4_b_cycle_rdy", 64'(AWREADY_M), 64'(0));
    cyc();
    man_bdone = '0;
    auto_en = 1'b1;
    @(negedge ACLK);
    chk("t4_after_b_rdy", 64'(AWREADY_M), 64'(2'b10));
    cyc();
    AWVALID_M = '0;
    wait_done("t4");

    // Reset mid-SEND: pointer is at M1 before the reset, M0 must win after.
    run_one(0, 32'h0001_0040, 4'd8, "t5_pre");
    auto_en = 1'b0;
    cyc();
    set_m(1, 32'h0001_0000, 4'd9, 4'd0, 3'd0, 2'd1);
    AWVALID_M = 2'b10;
    @(negedge ACLK);
    chk("t5_gnt_m1", 64'(AWREADY_M), 64'(2'b10));
    cyc();
    AWVALID_M = '0;
    @(negedge ACLK);
    chk("t5_send", 64'(AWVALID_S), 64'(6'b000001));
    #2;
    ARESET = 1'b1;
    #1;
    chk("t5_rst_vlds", 64'(AWVALID_S), 64'(0));
    chk("t5_rst_route_m", 64'(route_m), 64'(0));
    chk("t5_rst_addr", 64'(AWADDR_S), 64'(0));
    cyc();
    ARESET = 1'b0;
    auto_en = 1'b1;
    set_m(0, 32'h0002_8000, 4'd9, 4'd5, 3'd2, 2'd1);
    AWVALID_M = 2'b11;
    push_exp(0, 32'h0002_8000, 4'd9, 4'd5, 3'd2, 2'd1);
    @(negedge ACLK);
    chk("t5_ptr_reset", 64'(AWREADY_M), 64'(2'b01));
    cyc();
    AWVALID_M = '0;
    wait_done("t5");
    chk("sb_empty_end", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
